// File: rtl/coin_if.sv
// coin_if: coin sensor, credit, deduct and refund signals between the acceptor and the vend controller.
interface coin_if #(
  parameter int CODE_W   = 2,
  parameter int VALUE_W  = 5,
  parameter int CREDIT_W = 8
);
  logic [CODE_W-1:0]   coin_in;
  logic                coin_valid;
  logic                coin_reject;
  logic                coin_return;
  logic [VALUE_W-1:0]  coin_value;
  logic [CREDIT_W-1:0] credit;
  logic                deduct_req;
  logic [CREDIT_W-1:0] deduct_amt;
  logic                deduct_ack;
  logic                deduct_ok;
  logic                credit_clr;
  logic                refund_valid;
  logic [CREDIT_W-1:0] refund_value;
  modport master (
    output coin_in, deduct_req, deduct_amt, credit_clr,
    input  coin_valid, coin_reject, coin_return, coin_value, credit,
           deduct_ack, deduct_ok, refund_valid, refund_value
  );
  modport slave (
    input  coin_in, deduct_req, deduct_amt, credit_clr,
    output coin_valid, coin_reject, coin_return, coin_value, credit,
           deduct_ack, deduct_ok, refund_valid, refund_value
  );
endinterface

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces the coded coin bus, maps coins to values and keeps a saturating credit
// with deduct and refund paths.
module coin_acceptor #(
  parameter int CODE_W     = 2,
  parameter int VALUE_W    = 5,
  parameter logic [(2**CODE_W)*VALUE_W-1:0] COIN_VALUES = {5'd10, 5'd5, 5'd1, 5'd0},
  parameter int DEBOUNCE   = 4,
  parameter int CREDIT_W   = 8,
  parameter int CREDIT_MAX = 200
) (
  input logic clk,
  input logic rst,
  coin_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  typedef enum logic [1:0] {IDLE, QUAL, RELEASE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CODE_W-1:0] code, code_nx;
  logic run_new, run_same, qual;
  logic [VALUE_W-1:0] value;
  logic [CREDIT_W-1:0] base;
  logic [CREDIT_W:0] sum;
  logic ded_ok, fits, accept;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RELEASE;
      cnt   <= '0;
      code  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      code  <= code_nx;
    end
  // A new run starts from IDLE or when a different nonzero code appears mid-qualify.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    code_nx  = code;
    qual     = 1'b0;
    run_new  = bus.coin_in != '0 && (state == IDLE || (state == QUAL && bus.coin_in != code));
    run_same = state == QUAL && bus.coin_in == code;
    if (run_new || run_same) begin
      cnt_nx   = run_new ? CNT_W'(1) : cnt + CNT_W'(1);
      code_nx  = bus.coin_in;
      qual     = cnt_nx == CNT_W'(DEBOUNCE);
      state_nx = qual ? RELEASE : QUAL;
      cnt_nx   = qual ? '0 : cnt_nx;
    end else if (state == QUAL) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (state == RELEASE) begin
      cnt_nx   = bus.coin_in != '0 ? '0 : cnt + CNT_W'(1);
      state_nx = cnt_nx == CNT_W'(DEBOUNCE) ? IDLE : RELEASE;
      cnt_nx   = cnt_nx == CNT_W'(DEBOUNCE) ? '0 : cnt_nx;
    end
  end
  // Clear beats deduct; the coin is then judged against whatever credit survives.
  always_comb begin
    value  = COIN_VALUES[bus.coin_in * VALUE_W +: VALUE_W];
    ded_ok = !bus.credit_clr && bus.deduct_req && bus.credit >= bus.deduct_amt;
    base   = bus.credit_clr ? '0 : ded_ok ? bus.credit - bus.deduct_amt : bus.credit;
    sum    = {1'b0, base} + (CREDIT_W + 1)'(value);
    fits   = sum <= (CREDIT_W + 1)'(CREDIT_MAX);
    accept = qual && value != '0 && fits;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.coin_valid   <= 1'b0;
      bus.coin_reject  <= 1'b0;
      bus.coin_return  <= 1'b0;
      bus.coin_value   <= '0;
      bus.credit       <= '0;
      bus.deduct_ack   <= 1'b0;
      bus.deduct_ok    <= 1'b0;
      bus.refund_valid <= 1'b0;
      bus.refund_value <= '0;
    end else begin
      bus.coin_valid   <= accept;
      bus.coin_reject  <= qual && value == '0;
      bus.coin_return  <= qual && value != '0 && !fits;
      bus.coin_value   <= qual ? value : bus.coin_value;
      bus.credit       <= accept ? sum[CREDIT_W-1:0] : base;
      bus.deduct_ack   <= bus.deduct_req;
      bus.deduct_ok    <= ded_ok;
      bus.refund_valid <= bus.credit_clr;
      bus.refund_value <= bus.credit_clr ? bus.credit : bus.refund_value;
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed vectors for debounce, saturation, deduct, clear, reset and invalid coins.
module tb_coin_acceptor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0, errs = 0;
  int nv = 0, nrj = 0, nrt = 0;
  logic last_val, last_ret, last_rej;
  coin_if b ();
  coin_if b2 ();
  coin_acceptor dut (.clk(clk), .rst(rst), .bus(b));
  coin_acceptor #(.COIN_VALUES({5'd10, 5'd5, 5'd0, 5'd0})) dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    nv += int'(b.coin_valid);
    nrj += int'(b.coin_reject);
    nrt += int'(b.coin_return);
  endtask
  task automatic run(input logic [1:0] c, input int n);
    b.coin_in = c;
    repeat (n) tick();
  endtask
  task automatic insert(input logic [1:0] c);
    run(c, 4);
    last_val = b.coin_valid;
    last_ret = b.coin_return;
    last_rej = b.coin_reject;
    run(2'b00, 4);
  endtask
  task automatic deduct(input logic [7:0] amt);
    b.deduct_req = 1'b1;
    b.deduct_amt = amt;
    tick();
    b.deduct_req = 1'b0;
  endtask
  initial begin
    b.coin_in = '0; b.deduct_req = 0; b.deduct_amt = '0; b.credit_clr = 0;
    b2.coin_in = '0; b2.deduct_req = 0; b2.deduct_amt = '0; b2.credit_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", b.credit, 0);
    chk("rst_value", b.coin_value, 0);
    chk("rst_refund", b.refund_value, 0);
    chk("rst_valid", b.coin_valid, 0);
    chk("rst_ack", b.deduct_ack, 0);
    rst = 1'b0;
    run(2'b00, 5);
    nv = 0;
    run(2'b10, 3);
    chk("t1_early", b.coin_valid, 0);
    tick();
    chk("t1_valid", b.coin_valid, 1);
    chk("t1_value", b.coin_value, 5);
    chk("t1_credit", b.credit, 5);
    run(2'b10, 2);
    run(2'b00, 4);
    chk("t1_once", nv, 1);
    nv = 0;
    run(2'b01, 3);
    run(2'b00, 1);
    run(2'b01, 3);
    chk("bounce_none", nv, 0);
    tick();
    chk("bounce_valid", b.coin_valid, 1);
    run(2'b00, 4);
    chk("bounce_once", nv, 1);
    chk("bounce_credit", b.credit, 6);
    insert(2'b11);
    deduct(8'd1);
    chk("ded1_ok", b.deduct_ok, 1);
    chk("ded1_credit", b.credit, 15);
    tick();
    chk("ded1_ack_low", b.deduct_ack, 0);
    deduct(8'd20);
    chk("ded20_ack", b.deduct_ack, 1);
    chk("ded20_ok", b.deduct_ok, 0);
    chk("ded20_credit", b.credit, 15);
    deduct(8'd15);
    chk("ded15_ok", b.deduct_ok, 1);
    chk("ded15_credit", b.credit, 0);
    for (int i = 0; i < 19; i++) insert(2'b11);
    insert(2'b10);
    chk("sat_pre", b.credit, 195);
    insert(2'b11);
    chk("sat_return", last_ret, 1);
    chk("sat_novalid", last_val, 0);
    chk("sat_credit", b.credit, 195);
    insert(2'b10);
    chk("sat_fill", last_val, 1);
    chk("sat_200", b.credit, 200);
    insert(2'b01);
    chk("sat_201", last_ret, 1);
    chk("sat_hold", b.credit, 200);
    deduct(8'd190);
    chk("ded190", b.credit, 10);
    run(2'b10, 3);
    b.deduct_req = 1'b1;
    b.deduct_amt = 8'd10;
    tick();
    b.deduct_req = 1'b0;
    chk("sim_valid", b.coin_valid, 1);
    chk("sim_ok", b.deduct_ok, 1);
    chk("sim_credit", b.credit, 5);
    run(2'b00, 4);
    insert(2'b10);
    chk("clr_pre", b.credit, 10);
    run(2'b10, 3);
    b.deduct_req = 1'b1;
    b.deduct_amt = 8'd10;
    b.credit_clr = 1'b1;
    tick();
    b.deduct_req = 1'b0;
    b.credit_clr = 1'b0;
    chk("clr_refund_v", b.refund_valid, 1);
    chk("clr_refund", b.refund_value, 10);
    chk("clr_credit", b.credit, 5);
    chk("clr_ack", b.deduct_ack, 1);
    chk("clr_ok", b.deduct_ok, 0);
    chk("clr_valid", b.coin_valid, 1);
    tick();
    chk("clr_pulse_end", b.refund_valid, 0);
    chk("clr_hold", b.refund_value, 10);
    run(2'b00, 4);
    nv = 0; nrj = 0; nrt = 0;
    run(2'b11, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_credit", b.credit, 0);
    run(2'b11, 8);
    chk("rst2_nopulse", nv + nrj + nrt, 0);
    run(2'b00, 4);
    insert(2'b11);
    chk("rst2_reinsert", last_val, 1);
    chk("rst2_credit10", b.credit, 10);
    b2.coin_in = 2'b10;
    repeat (4) tick();
    chk("inv_ok_credit", b2.credit, 5);
    b2.coin_in = 2'b00;
    repeat (4) tick();
    b2.coin_in = 2'b01;
    repeat (4) tick();
    chk("inv_reject", b2.coin_reject, 1);
    chk("inv_novalid", b2.coin_valid, 0);
    chk("inv_value", b2.coin_value, 0);
    chk("inv_credit", b2.credit, 5);
    b2.coin_in = 2'b00;
    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
